// File: rtl/i2c_target.sv
// I2C target with a byte-wide register interface: a register pointer write, then
// auto-incrementing data writes or reads. SCL is never driven; SDA is open-drain.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h21,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic       bus_clk,
  input  logic       rst_n,
  input  logic       i2c_clk,
  inout  wire        i2c_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StSub      = 4'd3;
  localparam logic [3:0] StSubAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRdataAck = 4'd8;
  localparam logic [3:0] StIgnore   = 4'd9;

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_release_q, sda_release_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       rd_pend_q, rd_pend_d;
  logic       load_q, load_d;
  logic       busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  // Open-drain emulation: I tied low, T driven by sda_release.
  assign i2c_data = sda_release_q ? 1'bz : 1'b0;

  // A level is accepted only once the whole sample history agrees.
  always_ff @(posedge bus_clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_clk};
      sda_sync_q <= {sda_sync_q[0], i2c_data};
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
      if (&scl_hist_q)       scl_f_q <= 1'b1;
      else if (~|scl_hist_q) scl_f_q <= 1'b0;
      if (&sda_hist_q)       sda_f_q <= 1'b1;
      else if (~|sda_hist_q) sda_f_q <= 1'b0;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q & scl_prev_q;
  assign start_det = scl_f_q & sda_prev_q & ~sda_f_q;
  assign stop_det  = scl_f_q & ~sda_prev_q & sda_f_q;
  assign byte_in   = {shift_q[6:0], sda_f_q};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rw_d          = rw_q;
    phase_d       = phase_q;
    sda_release_d = sda_release_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    reg_wr_d      = 1'b0;
    reg_rd_d      = rd_pend_q;
    rd_pend_d     = 1'b0;
    load_d        = reg_rd_q;
    busy_d        = busy_q;

    if (reg_wr_q) reg_addr_d = reg_addr_q + 8'd1;

    case (state_q)
      StIdle: sda_release_d = 1'b1;
      StAddr, StSub, StWdata: begin
        if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_d = 1'b0;
            if (state_q == StSub) begin
              reg_addr_d = byte_in;
              state_d    = StSubAck;
            end else if (state_q == StWdata) begin
              reg_wdata_d = byte_in;
              state_d     = StWdataAck;
            end else if (byte_in[7:1] == TARGET_ADDR) begin
              state_d  = StAddrAck;
              rw_d     = byte_in[0];
              busy_d   = 1'b1;
              reg_rd_d = byte_in[0];
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end
      end
      StAddrAck, StSubAck, StWdataAck: begin
        if (scl_fall) begin
          if (!phase_q) begin
            sda_release_d = 1'b0;
            phase_d       = 1'b1;
            reg_wr_d      = (state_q == StWdataAck);
          end else begin
            phase_d       = 1'b0;
            cnt_d         = 3'd0;
            sda_release_d = 1'b1;
            if (state_q == StAddrAck && rw_q) begin
              state_d       = StRdata;
              sda_release_d = shift_q[7];
            end else if (state_q == StAddrAck) begin
              state_d = StSub;
            end else begin
              state_d = StWdata;
            end
          end
        end
      end
      StRdata: begin
        // shift_q[7] is always the bit currently on the bus.
        if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_release_d = 1'b1;
            state_d       = StRdataAck;
            phase_d       = 1'b0;
          end else begin
            cnt_d         = cnt_q + 3'd1;
            shift_d       = {shift_q[6:0], 1'b0};
            sda_release_d = shift_q[6];
          end
        end
      end
      StRdataAck: begin
        if (scl_rise && !phase_q) begin
          if (!sda_f_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
            rd_pend_d  = 1'b1;
            phase_d    = 1'b1;
          end else begin
            state_d = StIgnore;
          end
        end else if (scl_fall && phase_q) begin
          state_d       = StRdata;
          cnt_d         = 3'd0;
          phase_d       = 1'b0;
          sda_release_d = shift_q[7];
        end
      end
      StIgnore: sda_release_d = 1'b1;
      default:  state_d = StIdle;
    endcase

    if (load_q) shift_d = reg_rdata;

    if (start_det) begin
      state_d       = StAddr;
      cnt_d         = 3'd0;
      phase_d       = 1'b0;
      sda_release_d = 1'b1;
    end
    // STOP overrides a coincident START.
    if (stop_det) begin
      state_d       = StIdle;
      sda_release_d = 1'b1;
      busy_d        = 1'b0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      shift_q       <= 8'd0;
      rw_q          <= 1'b0;
      phase_q       <= 1'b0;
      sda_release_q <= 1'b1;
      reg_addr_q    <= 8'd0;
      reg_wdata_q   <= 8'd0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      load_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rw_q          <= rw_d;
      phase_q       <= phase_d;
      sda_release_q <= sda_release_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      rd_pend_q     <= rd_pend_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
    end
  end

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;

endmodule
